// File: rtl/bpsk_pkg.sv
// Shared definitions for the streaming BPSK demodulator.
//   SYM_ZERO / SYM_ONE : the two legal BPSK symbol encodings
//   state_t            : word-assembly FSM states
//   MODE_HAMMING/BCH   : values of the mode input / m_len output
package bpsk_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b01;
  localparam logic [1:0] SYM_ONE  = 2'b10;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  localparam logic MODE_HAMMING = 1'b0;
  localparam logic MODE_BCH     = 1'b1;

endpackage

// File: rtl/bpsk_sym_slicer.sv
// Combinational hard-decision slicer for one 2-bit BPSK symbol.
//   sym : received symbol
//   dec : decided bit (SYM_ZERO -> 0, anything else -> 1)
//   inv : symbol is neither SYM_ZERO nor SYM_ONE
module bpsk_sym_slicer
  import bpsk_pkg::*;
(
  input  logic [1:0] sym,
  output logic       dec,
  output logic       inv
);

  always_comb begin
    dec = (sym != SYM_ZERO);
    inv = !((sym == SYM_ZERO) || (sym == SYM_ONE));
  end

endmodule

// File: rtl/bpsk_demod_stream.sv
// Streaming BPSK demodulator: slices one symbol per input beat and assembles
// the decisions LSB-first into N_A-bit (mode=0) or N_B-bit (mode=1) words,
// presented on a registered valid/ready output.
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr               : synchronous discard of the partial word
//   mode              : word length select, sampled on a word's first symbol
//   s_valid/s_ready   : input handshake, s_sym = 2-bit symbol
//   m_valid/m_ready   : output handshake
//   m_data            : word, bit i = symbol i, unused high bits zero
//   m_len             : mode the word was assembled with
//   m_err             : word contained a 2'b00 or 2'b11 symbol
// Optional macro BPSK_DEMOD_STATS_EN adds saturating counters
//   word_cnt (output handshakes) and err_sym_cnt (accepted invalid symbols).
module bpsk_demod_stream
  import bpsk_pkg::*;
#(
  parameter int N_A   = 12,
  parameter int N_B   = 15,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           mode,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [1:0]     s_sym,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N_B-1:0] m_data,
  output logic           m_len,
  output logic           m_err
`ifdef BPSK_DEMOD_STATS_EN
  ,
  output logic [15:0]    word_cnt,
  output logic [15:0]    err_sym_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(N_A - 1);
  localparam logic [CNT_W-1:0] LAST_B = CNT_W'(N_B - 1);
  localparam logic [N_B-1:0]   ONES   = '1;
  localparam logic [N_B-1:0]   MASK_A = ~(ONES << N_A);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             len_q;
  logic             acc;
  logic [N_B-1:0]   sr;

  logic             dec;
  logic             inv;
  logic             at_last;
  logic             accept;
  logic             take;
  logic             word_done;
  logic [N_B-1:0]   word_next;

  bpsk_sym_slicer u_slicer (
    .sym (s_sym),
    .dec (dec),
    .inv (inv)
  );

  always_comb begin
    at_last   = (state == COLLECT) &&
                (cnt == ((len_q == MODE_BCH) ? LAST_B : LAST_A));
    // Only the word-completing symbol has to wait for the output register.
    s_ready   = !(at_last && m_valid && !m_ready);
    accept    = s_valid && s_ready;
    // clr wins over a coincident accept: the symbol is dropped.
    take      = accept && !clr;
    word_done = take && at_last;
    word_next = (sr | (N_B'(dec) << cnt)) &
                ((len_q == MODE_BCH) ? ONES : MASK_A);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= MODE_HAMMING;
      acc   <= 1'b0;
      sr    <= '0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= 1'b0;
      sr    <= '0;
    end else if (take) begin
      unique case (state)
        IDLE: begin
          len_q <= mode;
          sr    <= N_B'(dec);
          cnt   <= CNT_W'(1);
          acc   <= inv;
          state <= COLLECT;
        end
        COLLECT: begin
          if (at_last) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= 1'b0;
            sr    <= '0;
          end else begin
            sr  <= sr | (N_B'(dec) << cnt);
            cnt <= cnt + CNT_W'(1);
            acc <= acc | inv;
          end
        end
      endcase
    end
  end

  // Output register: a completing word reloads even during a handshake,
  // so m_valid stays high back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_len   <= 1'b0;
      m_err   <= 1'b0;
    end else if (word_done) begin
      m_valid <= 1'b1;
      m_data  <= word_next;
      m_len   <= len_q;
      m_err   <= acc | inv;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef BPSK_DEMOD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt    <= '0;
      err_sym_cnt <= '0;
    end else begin
      if (m_valid && m_ready && (word_cnt != '1))
        word_cnt <= word_cnt + 16'd1;
      if (take && inv && (err_sym_cnt != '1))
        err_sym_cnt <= err_sym_cnt + 16'd1;
    end
  end
`endif

endmodule
